// File: rtl/ta_bank.sv
// rtl/ta_bank.sv - clause-level bank of Tsetlin automata with serial Type I/II feedback
//
// Purpose:
//   N_LIT Tsetlin automata forming one clause. EVAL computes the AND of the
//   literals whose automaton is in an include state. In training, UPDATE then
//   visits one automaton per cycle. The stochastic decisions take their random
//   byte from an internal 16-bit Fibonacci LFSR.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request, accepted only while ready=1
//   train        1 = evaluate then train, 0 = inference only
//   fb_type      0 = Type I feedback, 1 = Type II feedback
//   fb_en        0 = training skips every state update
//   literals     literal vector, sampled together with start
//   rd_idx       automaton index for state readback
//   ready        FSM is idle
//   done         one-cycle pulse, clause_out valid
//   clause_out   registered clause result
//   include_mask MSB of every automaton state
//   rd_state     state of automaton rd_idx
module ta_bank #(
  parameter int          N_LIT      = 8,
  parameter int          STATE_BITS = 3,
  parameter int          P_HI       = 224,
  parameter int          P_LO       = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  localparam int         IW         = (N_LIT > 1) ? $clog2(N_LIT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  train,
  input  logic                  fb_type,
  input  logic                  fb_en,
  input  logic [N_LIT-1:0]      literals,
  input  logic [IW-1:0]         rd_idx,
  output logic                  ready,
  output logic                  done,
  output logic                  clause_out,
  output logic [N_LIT-1:0]      include_mask,
  output logic [STATE_BITS-1:0] rd_state
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_UPDATE, S_DONE} state_e;

  localparam logic [15:0]           SEED    = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [STATE_BITS-1:0] ST_INIT = STATE_BITS'((1 << (STATE_BITS - 1)) - 1);
  localparam logic [STATE_BITS-1:0] ST_MAX  = {STATE_BITS{1'b1}};
  // 9-bit thresholds so that 256 means "always" against an 8-bit random byte
  localparam logic [8:0]            P_HI_W  = 9'(P_HI);
  localparam logic [8:0]            P_LO_W  = 9'(P_LO);

  state_e                               state_q, state_d;
  logic [N_LIT-1:0][STATE_BITS-1:0]     ta_q, ta_d;
  logic [N_LIT-1:0]                     lit_q, lit_d;
  logic                                 train_q, train_d;
  logic                                 fbt_q, fbt_d;
  logic                                 fben_q, fben_d;
  logic                                 clause_q, clause_d;
  logic [IW-1:0]                        idx_q, idx_d;
  logic [15:0]                          lfsr_q, lfsr_d;
  logic                                 lfsr_fb;

  function automatic logic [STATE_BITS-1:0] ta_next(
    input logic [STATE_BITS-1:0] cur,
    input logic                  lit,
    input logic                  cl,
    input logic                  ft,
    input logic [7:0]            r
  );
    logic up;
    logic dn;
    logic hi_ok;
    logic lo_ok;
    up    = 1'b0;
    dn    = 1'b0;
    hi_ok = ({1'b0, r} < P_HI_W);
    lo_ok = ({1'b0, r} < P_LO_W);
    if (!ft) begin
      if (cl && lit) up = hi_ok;
      else           dn = lo_ok;
    end else begin
      // Type II only pushes excluded automata of false literals toward include
      up = cl && !lit && !cur[STATE_BITS-1];
    end
    if (up && cur != ST_MAX)       return cur + 1'b1;
    else if (dn && cur != '0)      return cur - 1'b1;
    else                           return cur;
  endfunction

  always_comb begin
    for (int i = 0; i < N_LIT; i++) include_mask[i] = ta_q[i][STATE_BITS-1];
  end

  // Decoded readback avoids out-of-range indexing when N_LIT is not a power of two
  always_comb begin
    rd_state = '0;
    for (int i = 0; i < N_LIT; i++) begin
      if (rd_idx == IW'(i)) rd_state = ta_q[i];
    end
  end

  assign lfsr_fb    = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign ready      = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign clause_out = clause_q;

  always_comb begin
    state_d  = state_q;
    ta_d     = ta_q;
    lit_d    = lit_q;
    train_d  = train_q;
    fbt_d    = fbt_q;
    fben_d   = fben_q;
    clause_d = clause_q;
    idx_d    = idx_q;
    lfsr_d   = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lit_d   = literals;
          train_d = train;
          fbt_d   = fb_type;
          fben_d  = fb_en;
          idx_d   = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // An empty clause is true while learning so Type I can start including
        if (include_mask == '0) clause_d = train_q;
        else                    clause_d = &(lit_q | ~include_mask);
        state_d = (train_q && fben_q) ? S_UPDATE : S_DONE;
      end
      S_UPDATE: begin
        for (int i = 0; i < N_LIT; i++) begin
          if (idx_q == IW'(i)) ta_d[i] = ta_next(ta_q[i], lit_q[i], clause_q, fbt_q, lfsr_q[7:0]);
        end
        lfsr_d = {lfsr_fb, lfsr_q[15:1]};
        idx_d  = idx_q + 1'b1;
        if (idx_q == IW'(N_LIT - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ta_q     <= {N_LIT{ST_INIT}};
      lit_q    <= '0;
      train_q  <= 1'b0;
      fbt_q    <= 1'b0;
      fben_q   <= 1'b0;
      clause_q <= 1'b0;
      idx_q    <= '0;
      lfsr_q   <= SEED;
    end else begin
      state_q  <= state_d;
      ta_q     <= ta_d;
      lit_q    <= lit_d;
      train_q  <= train_d;
      fbt_q    <= fbt_d;
      fben_q   <= fben_d;
      clause_q <= clause_d;
      idx_q    <= idx_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule
